// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : run_ctrl_pkg
// Purpose  : Shared definitions for the run/lifecycle controller: the FSM
//            state encoding and the default halt instruction encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package run_ctrl_pkg;

    // Lifecycle states of the controller.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // RV32 ECALL: the instruction a test program executes to end the run.
    localparam logic [31:0] C_HALT_ECALL = 32'h0000_0073;

endpackage : run_ctrl_pkg
`default_nettype wire

// File: rtl/run_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter with synchronous clear that sticks at all-ones
//            instead of wrapping. Clear has priority over increment.
// Ports    : clk_i   - clock, rising edge
//            rst_ni  - asynchronous active-low reset (count -> 0)
//            clr_i   - synchronous clear
//            inc_i   - increment request
//            cnt_o   - current count (registered)
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter
    import run_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : run_ctrl
// Purpose  : Run/lifecycle controller for an RV32 core. Holds the core in
//            reset for RST_CYCLES cycles after a start pulse, lets it run,
//            counts cycles and retirements, and ends the run on a halt
//            instruction or when the cycle budget expires, reporting a
//            pass/fail verdict.
// Ports    : clk_i, rst_ni          - clock / async active-low reset
//            start_i                - run start pulse (IDLE or DONE only)
//            inst_i, inst_valid_i   - retired instruction and its strobe
//            result_i               - core a0, captured at halt
//            core_rst_o             - active-high reset to the core
//            running_o, done_o      - lifecycle status
//            pass_o, timeout_o      - verdict, valid while done_o
//            cycle_cnt_o, inst_cnt_o- RUN cycle / retirement counters
//            exit_code_o            - result_i captured at halt
//            last_inst_o            - (RUN_CTRL_TRACE_EN only) last retired
//                                     instruction
// Options  : RUN_CTRL_TRACE_EN adds last_inst_o and simulation trace output.
// Revision : 1.0 - initial release
// ============================================================================
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              CNT_W      = 32,
    parameter int              RST_CYCLES = 2,
    parameter int              TIMEOUT    = 12,
    parameter logic [XLEN-1:0] HALT_INST  = XLEN'(C_HALT_ECALL)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [XLEN-1:0]  inst_i,
    input  logic             inst_valid_i,
    input  logic [XLEN-1:0]  result_i,
    output logic             core_rst_o,
    output logic             running_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] inst_cnt_o,
    output logic [XLEN-1:0]  exit_code_o
`ifdef RUN_CTRL_TRACE_EN
    ,
    output logic [XLEN-1:0]  last_inst_o
`endif
);

    // rst_cnt only needs to reach RST_CYCLES-1.
    localparam int              C_RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [C_RST_W-1:0] C_RST_LAST = C_RST_W'(RST_CYCLES - 1);
    // Compared at 64 bits so a narrow counter never aliases the budget.
    localparam logic [63:0]     C_TO_LAST  = 64'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              core_rst_q, running_q, done_q;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [XLEN-1:0]   exit_q, exit_d;

    logic              start_ok;
    logic              rst_inc, cyc_inc, inst_inc;
    logic              halt, to_hit;
    logic [C_RST_W-1:0] rst_cnt;
    logic [CNT_W-1:0]  cycle_cnt, inst_cnt;

    assign halt   = inst_valid_i && (inst_i == HALT_INST);
    assign to_hit = (64'(cycle_cnt) == C_TO_LAST);

    // Next-state and verdict logic.
    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        exit_d    = exit_q;
        start_ok  = 1'b0;
        rst_inc   = 1'b0;
        cyc_inc   = 1'b0;
        inst_inc  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d   = ST_RESET;
                    start_ok  = 1'b1;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    exit_d    = '0;
                end
            end
            ST_RESET: begin
                rst_inc = 1'b1;
                if (rst_cnt == C_RST_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                inst_inc = inst_valid_i;
                if (halt) begin
                    // Halt takes priority over a coincident timeout.
                    state_d   = ST_DONE;
                    exit_d    = result_i;
                    pass_d    = (result_i == '0);
                    timeout_d = 1'b0;
                end else if (to_hit) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    // The final RUN cycle is not counted, so a timed-out
                    // run reports TIMEOUT-1.
                    cyc_inc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            core_rst_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            exit_q     <= '0;
        end else begin
            state_q    <= state_d;
            core_rst_q <= (state_d != ST_RUN);
            running_q  <= (state_d == ST_RUN);
            done_q     <= (state_d == ST_DONE);
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            exit_q     <= exit_d;
        end
    end

    sat_counter #(.W(C_RST_W)) u_rst_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (start_ok),
        .inc_i  (rst_inc),
        .cnt_o  (rst_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (start_ok),
        .inc_i  (cyc_inc),
        .cnt_o  (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_inst_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (start_ok),
        .inc_i  (inst_inc),
        .cnt_o  (inst_cnt)
    );

    assign core_rst_o  = core_rst_q;
    assign running_o   = running_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign cycle_cnt_o = cycle_cnt;
    assign inst_cnt_o  = inst_cnt;
    assign exit_code_o = exit_q;

`ifdef RUN_CTRL_TRACE_EN
    logic [XLEN-1:0] last_inst_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_inst_q <= '0;
        end else if ((state_q == ST_RUN) && inst_valid_i) begin
            last_inst_q <= inst_i;
        end
    end

    assign last_inst_o = last_inst_q;

    // Simulation-only trace of retirements and the final verdict.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if ((state_q == ST_RUN) && inst_valid_i) begin
                $display("run_ctrl: cycle %0d retire %h", cycle_cnt, inst_i);
            end
            if ((state_q == ST_RUN) && (state_d == ST_DONE)) begin
                $display("run_ctrl: done pass=%0b timeout=%0b exit=%h",
                         pass_d, timeout_d, exit_d);
            end
        end
    end
`else
    // Trace disabled: no last_inst_o port and no display output.
`endif

endmodule : run_ctrl
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_ctrl
// Purpose  : Self-checking bench for run_ctrl: a directed vector table,
//            hand-written corner-case runs, randomized stimulus against a
//            behavioural model, and a narrow-counter instance for saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_ctrl;

    localparam logic [31:0] C_NOP   = 32'h0000_0013;
    localparam logic [31:0] C_ECALL = 32'h0000_0073;
    localparam int          C_RSTC  = 2;
    localparam int          C_TO    = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] result;

    logic        core_rst, running, done, pass, timeout;
    logic [31:0] cycle_cnt, inst_cnt, exit_code;

    logic        c2_core_rst, c2_running, c2_done, c2_pass, c2_timeout;
    logic [2:0]  c2_cycle_cnt, c2_inst_cnt;
    logic [31:0] c2_exit_code;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    run_ctrl #(.XLEN(32), .CNT_W(32), .RST_CYCLES(C_RSTC), .TIMEOUT(C_TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .inst_i(inst),
        .inst_valid_i(inst_valid), .result_i(result), .core_rst_o(core_rst),
        .running_o(running), .done_o(done), .pass_o(pass), .timeout_o(timeout),
        .cycle_cnt_o(cycle_cnt), .inst_cnt_o(inst_cnt), .exit_code_o(exit_code)
    );

    // Narrow counters and a budget they cannot reach, to exercise saturation.
    run_ctrl #(.XLEN(32), .CNT_W(3), .RST_CYCLES(1), .TIMEOUT(100)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .inst_i(inst),
        .inst_valid_i(inst_valid), .result_i(result), .core_rst_o(c2_core_rst),
        .running_o(c2_running), .done_o(c2_done), .pass_o(c2_pass),
        .timeout_o(c2_timeout), .cycle_cnt_o(c2_cycle_cnt),
        .inst_cnt_o(c2_inst_cnt), .exit_code_o(c2_exit_code)
    );

    // ---------------- behavioural reference model ----------------
    bit          m_in_reset, m_running, m_done, m_pass, m_to;
    int          m_rst_left;
    logic [31:0] m_cyc, m_inst, m_exit;

    function automatic void model_reset();
        m_in_reset = 0; m_running = 0; m_done = 0; m_pass = 0; m_to = 0;
        m_rst_left = 0; m_cyc = '0; m_inst = '0; m_exit = '0;
    endfunction

    function automatic void model_edge(bit s, bit v, logic [31:0] ins, logic [31:0] res);
        bit halted;
        if (m_in_reset) begin
            m_rst_left = m_rst_left - 1;
            if (m_rst_left == 0) begin
                m_in_reset = 0;
                m_running  = 1;
            end
        end else if (m_running) begin
            halted = v && (ins == C_ECALL);
            if (v && m_inst != 32'hFFFF_FFFF) m_inst = m_inst + 1;
            if (halted) begin
                m_running = 0; m_done = 1; m_exit = res; m_pass = (res == 0); m_to = 0;
            end else if (m_cyc == C_TO - 1) begin
                m_running = 0; m_done = 1; m_to = 1; m_pass = 0;
            end else if (m_cyc != 32'hFFFF_FFFF) begin
                m_cyc = m_cyc + 1;
            end
        end else if (s) begin
            m_in_reset = 1; m_rst_left = C_RSTC; m_done = 0;
            m_cyc = '0; m_inst = '0; m_exit = '0; m_pass = 0; m_to = 0;
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " core_rst"}, 32'(core_rst), 32'(!m_running));
        chk({tag, " running"},  32'(running),  32'(m_running));
        chk({tag, " done"},     32'(done),     32'(m_done));
        chk({tag, " pass"},     32'(pass),     32'(m_pass));
        chk({tag, " timeout"},  32'(timeout),  32'(m_to));
        chk({tag, " cycle_cnt"}, cycle_cnt, m_cyc);
        chk({tag, " inst_cnt"},  inst_cnt,  m_inst);
        chk({tag, " exit_code"}, exit_code, m_exit);
    endtask

    task automatic drive(input bit s, input bit v, input logic [31:0] ins, input logic [31:0] res);
        start = s; inst_valid = v; inst = ins; result = res;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input bit s, input bit v,
                        input logic [31:0] ins, input logic [31:0] res);
        drive(s, v, ins, res);
        model_edge(s, v, ins, res);
        check_all(tag);
    endtask

    // Pulse the async reset between clock edges and check it took effect at once.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1 rst_n = 1'b1;
    endtask

    task automatic begin_run(input string tag);
        step(tag, 1, 0, '0, '0);
        for (int i = 0; i < C_RSTC; i++) step(tag, 0, 0, '0, '0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          s;
        bit          v;
        logic [31:0] ins;
        logic [31:0] res;
        bit          e_crst, e_run, e_done, e_pass, e_to;
        logic [31:0] e_cyc, e_inst, e_exit;
    } vec_t;

    vec_t tbl[8];

    initial begin : wdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst_n = 1'b0; start = 0; inst_valid = 0; inst = '0; result = '0;
        model_reset();

        //          s  v  inst     result      crst run done pass to cyc inst exit
        tbl[0] = '{1, 0, '0,      32'h0,      1,   0,  0,   0,   0, 0,  0,   0};
        tbl[1] = '{0, 1, C_NOP,   32'h0,      1,   0,  0,   0,   0, 0,  0,   0};
        tbl[2] = '{0, 0, '0,      32'h0,      0,   1,  0,   0,   0, 0,  0,   0};
        tbl[3] = '{0, 1, C_NOP,   32'h0,      0,   1,  0,   0,   0, 1,  1,   0};
        tbl[4] = '{0, 1, C_NOP,   32'h0,      0,   1,  0,   0,   0, 2,  2,   0};
        tbl[5] = '{0, 1, C_NOP,   32'h55,     0,   1,  0,   0,   0, 3,  3,   0};
        tbl[6] = '{0, 1, C_ECALL, 32'h0,      1,   0,  1,   1,   0, 3,  4,   0};
        tbl[7] = '{0, 1, C_NOP,   32'h9,      1,   0,  1,   1,   0, 3,  4,   0};

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].s, tbl[i].v, tbl[i].ins, tbl[i].res);
            model_edge(tbl[i].s, tbl[i].v, tbl[i].ins, tbl[i].res);
            chk($sformatf("tbl%0d core_rst", i), 32'(core_rst), 32'(tbl[i].e_crst));
            chk($sformatf("tbl%0d running", i),  32'(running),  32'(tbl[i].e_run));
            chk($sformatf("tbl%0d done", i),     32'(done),     32'(tbl[i].e_done));
            chk($sformatf("tbl%0d pass", i),     32'(pass),     32'(tbl[i].e_pass));
            chk($sformatf("tbl%0d timeout", i),  32'(timeout),  32'(tbl[i].e_to));
            chk($sformatf("tbl%0d cycle_cnt", i), cycle_cnt, tbl[i].e_cyc);
            chk($sformatf("tbl%0d inst_cnt", i),  inst_cnt,  tbl[i].e_inst);
            chk($sformatf("tbl%0d exit_code", i), exit_code, tbl[i].e_exit);
        end

        // Failing exit code.
        begin_run("res5");
        step("res5", 0, 1, C_NOP, 32'h0);
        step("res5", 0, 1, C_ECALL, 32'h5);
        chk("res5 done", 32'(done), 32'd1);
        chk("res5 pass", 32'(pass), 32'd0);
        chk("res5 exit_code", exit_code, 32'h5);
        chk("res5 inst_cnt", inst_cnt, 32'd2);

        // Timeout, with a start pulse mid-run that must be ignored.
        begin_run("tmo");
        for (int i = 0; i < C_TO; i++) begin
            step("tmo", (i == 4), i[0], C_NOP, 32'h0);
            if (i == C_TO - 2) chk("tmo still running", 32'(running), 32'd1);
        end
        chk("tmo done", 32'(done), 32'd1);
        chk("tmo timeout", 32'(timeout), 32'd1);
        chk("tmo pass", 32'(pass), 32'd0);
        chk("tmo cycle_cnt", cycle_cnt, 32'd11);
        chk("tmo core_rst", 32'(core_rst), 32'd1);

        // Halt on the very cycle the budget expires: halt wins.
        begin_run("race");
        for (int i = 0; i < C_TO - 1; i++) step("race", 0, 0, '0, '0);
        step("race", 0, 1, C_ECALL, 32'h7);
        chk("race timeout", 32'(timeout), 32'd0);
        chk("race done", 32'(done), 32'd1);
        chk("race exit_code", exit_code, 32'h7);
        chk("race cycle_cnt", cycle_cnt, 32'd11);

        // Async reset mid-run, then a clean run.
        begin_run("arst");
        for (int i = 0; i < 3; i++) step("arst", 0, 1, C_NOP, 32'h3);
        async_reset("arst mid-run");
        begin_run("clean");
        step("clean", 0, 1, C_NOP, 32'h0);
        step("clean", 0, 1, C_ECALL, 32'h0);
        chk("clean pass", 32'(pass), 32'd1);
        chk("clean inst_cnt", inst_cnt, 32'd2);
        chk("clean cycle_cnt", cycle_cnt, 32'd1);

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) begin
                async_reset("rnd arst");
            end else begin
                step("rnd",
                     ($urandom_range(7) == 0),
                     bit'($urandom_range(1)),
                     ($urandom_range(9) == 0) ? C_ECALL : $urandom(),
                     ($urandom_range(2) == 0) ? 32'h0 : $urandom());
            end
        end

        // Saturation on the 3-bit-counter instance.
        async_reset("sat arst");
        drive(1, 0, '0, '0);
        chk("sat reset core_rst", 32'(c2_core_rst), 32'd1);
        drive(0, 0, '0, '0);
        chk("sat run running", 32'(c2_running), 32'd1);
        chk("sat run cycle_cnt", 32'(c2_cycle_cnt), 32'd0);
        for (int i = 0; i < 10; i++) drive(0, 1, C_NOP, '0);
        chk("sat cycle_cnt", 32'(c2_cycle_cnt), 32'd7);
        chk("sat inst_cnt", 32'(c2_inst_cnt), 32'd7);
        chk("sat running", 32'(c2_running), 32'd1);
        drive(0, 1, C_ECALL, '0);
        chk("sat done", 32'(c2_done), 32'd1);
        chk("sat pass", 32'(c2_pass), 32'd1);
        chk("sat timeout", 32'(c2_timeout), 32'd0);
        chk("sat halt inst_cnt", 32'(c2_inst_cnt), 32'd7);
        chk("sat exit_code", c2_exit_code, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_run_ctrl
`default_nettype wire

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Run/lifecycle controller for the RV32 processor; sits between the top-level clock/reset and the core.
- Sequences the core reset for a parametrised number of cycles, then lets the core run.
- Counts cycles and retired instructions.
- Ends the run on a halt instruction or a cycle-budget timeout, and reports a pass/fail verdict.
- Replaces fixed-delay reset and fixed-length run sequencing with one reusable synthesizable block.

Parameters:
- XLEN, 32, instruction/result width.
- CNT_W, 32, width of cycle and instruction counters.
- RST_CYCLES, 2, cycles core_rst is held high after start (min 1).
- TIMEOUT, 12, maximum RUN cycles before timeout (min 1).
- HALT_INST, 32'h00000073, instruction encoding that ends the run (ECALL).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
- inst  input  XLEN  instruction retired this cycle.
- inst_valid  input  1  inst is valid (one retirement).
- result  input  XLEN  core x10 (a0) value, sampled at halt.
- core_rst  output  1  active-high reset to processor.
- running  output  1  high in RUN.
- done  output  1  high in DONE until next start.
- pass  output  1  valid when done; 1 = halted with result==0.
- timeout  output  1  valid when done; 1 = budget expired.
- cycle_cnt  output  CNT_W  RUN cycles elapsed.
- inst_cnt  output  CNT_W  instructions retired in RUN.
- exit_code  output  XLEN  result captured at halt.

Behaviour:
- States: IDLE, RESET, RUN, DONE. Encodings are defined in the package.
- Reset (RST=0, async): state=IDLE, core_rst=1, running=0, done=0, pass=0, timeout=0, all counters=0, exit_code=0.
- IDLE: core_rst=1. A start pulse moves to RESET, loads rst_cnt=0, and clears counters, pass, timeout and exit_code.
- RESET: core_rst=1; rst_cnt increments each cycle. When rst_cnt==RST_CYCLES-1, go to RUN; core_rst falls on the same edge. core_rst is therefore high for exactly RST_CYCLES cycles after the start edge.
- RUN: core_rst=0, running=1.
  - cycle_cnt increments every cycle.
  - inst_cnt increments on inst_valid.
  - Both counters saturate at all-ones and do not wrap.
- Halt: inst_valid && inst==HALT_INST in RUN. Registered effect next edge:
  - state=DONE, done=1, exit_code=result.
  - pass=(result==0), timeout=0.
  - The halt instruction is counted in inst_cnt.
- Timeout: in RUN, when cycle_cnt==TIMEOUT-1 and no halt this cycle:
  - state=DONE, done=1, timeout=1, pass=0.
- Halt and timeout in the same cycle: halt wins.
- DONE: core_rst=1 (core frozen); outputs hold. A start pulse starts a new run (to RESET).
- start while in RESET or RUN is ignored.
- RST asserted mid-run returns to IDLE immediately (async). Counters and verdict are lost.
- inst/inst_valid are ignored outside RUN.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro RUN_CTRL_TRACE_EN.
- Defined:
  - Adds output last_inst (XLEN): captures inst on every valid retirement in RUN; reset 0.
  - Adds a simulation-only $display of cycle_cnt and inst per retirement.
  - Adds a $display of the verdict on entering DONE.
- Undefined: no last_inst port, no display statements; behaviour is otherwise identical.

Decomposition:
- Package run_ctrl_pkg holds:
  - state encoding constants (IDLE=2'd0, RESET=2'd1, RUN=2'd2, DONE=2'd3);
  - the default HALT_INST constant (ECALL 32'h00000073).
- One natural sub-module: sat_counter (parametrised width; clear, increment, saturate). Instantiated for cycle_cnt, inst_cnt and rst_cnt.

Test Plan:
- Reset plus start, RST_CYCLES=2 -> core_rst high for exactly 2 cycles after the start edge, then running=1, cycle_cnt counts 0,1,2...
- Retire 3 NOPs (32'h00000013), then ECALL with result=0 -> done=1, pass=1, timeout=0, inst_cnt=4, exit_code=0, core_rst=1.
- ECALL with result=32'h5 -> done=1, pass=0, exit_code=32'h5.
- No halt, TIMEOUT=12 -> on the 12th RUN cycle edge: done=1, timeout=1, pass=0, cycle_cnt=11.
- ECALL on the same cycle the timeout condition hits -> halt wins: timeout=0, exit_code captured.
- Start pulse during RUN -> ignored, counters continue. RST low mid-RUN -> immediate IDLE, all outputs at reset values. A new start afterwards -> a clean run.
